// File: rtl/rle_pkg.sv
// Shared types and sizing helpers for the run-length word decompressor.
package rle_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    function automatic int calc_slots(input int sym_w, input int word_w);
        return word_w / sym_w;
    endfunction

    // One extra bit so that pos+k can reach SLOTS without wrapping.
    function automatic int calc_pos_w(input int sym_w, input int word_w);
        return $clog2(word_w / sym_w) + 1;
    endfunction

    function automatic int unsigned umin(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/rle_word_decompressor_slot_fill.sv
// Combinational slot writer: replaces slots pos..pos+k-1 of buffer with run_sym.
module rle_slot_fill
    import rle_pkg::*;
#(
    parameter int SYM_W  = 1,
    parameter int WORD_W = 32,
    parameter int POS_W  = 6
) (
    input  logic [POS_W-1:0]  pos,
    input  logic [POS_W-1:0]  k,
    input  logic [SYM_W-1:0]  run_sym,
    input  logic [WORD_W-1:0] buffer,
    output logic [WORD_W-1:0] buffer_next
);

    localparam int SLOTS = calc_slots(SYM_W, WORD_W);

    // Per-slot mask select between the incoming symbol and the old contents.
    always_comb begin
        buffer_next = buffer;
        for (int i = 0; i < SLOTS; i++) begin
            if ((i >= int'(pos)) && (i < (int'(pos) + int'(k)))) begin
                buffer_next[i*SYM_W +: SYM_W] = run_sym;
            end else begin
                buffer_next[i*SYM_W +: SYM_W] = buffer[i*SYM_W +: SYM_W];
            end
        end
    end

endmodule

// File: rtl/rle_word_decompressor.sv
// Run-length decompressor: expands (symbol, length) runs into packed output words.
// Optional flush/out_last ports are enabled by defining RLE_FLUSH_EN.
module rle_word_decompressor
    import rle_pkg::*;
#(
    parameter int SYM_W  = 1,
    parameter int WORD_W = 32,
    parameter int LEN_W  = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SYM_W-1:0]  in_sym,
    input  logic [LEN_W-1:0]  in_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data
`ifdef RLE_FLUSH_EN
    ,
    input  logic              flush,
    output logic              out_last
`endif
);

    localparam int SLOTS = calc_slots(SYM_W, WORD_W);
    localparam int POS_W = calc_pos_w(SYM_W, WORD_W);

    state_t            state_r, state_s;
    logic [SYM_W-1:0]  run_sym_r, run_sym_s;
    logic [LEN_W-1:0]  run_rem_r, run_rem_s;
    logic [POS_W-1:0]  pos_r, pos_s;
    logic [WORD_W-1:0] buf_r, buf_s;
    logic              out_valid_r, out_valid_s;
    logic [WORD_W-1:0] out_data_r, out_data_s;
    logic [POS_W-1:0]  k_s;
    logic [WORD_W-1:0] fill_buf_s;
    logic              stall_s;
    logic              word_done_s;
    logic              flush_req_s;
`ifdef RLE_FLUSH_EN
    logic              last_r, last_s;
`endif

    assign stall_s     = out_valid_r && !out_ready;
    assign k_s         = POS_W'(umin(32'(run_rem_r), 32'(SLOTS) - 32'(pos_r)));
    assign word_done_s = ((pos_r + k_s) == POS_W'(SLOTS));
`ifdef RLE_FLUSH_EN
    assign flush_req_s = flush && (state_r == IDLE);
    assign out_last    = last_r;
`else
    assign flush_req_s = 1'b0;
`endif
    assign in_ready    = (state_r == IDLE) && !flush_req_s;
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;

    rle_slot_fill #(
        .SYM_W  (SYM_W),
        .WORD_W (WORD_W),
        .POS_W  (POS_W)
    ) u_slot_fill (
        .pos         (pos_r),
        .k           (k_s),
        .run_sym     (run_sym_r),
        .buffer      (buf_r),
        .buffer_next (fill_buf_s)
    );

    // Next-state: run capture, slot expansion, word hand-off and flush.
    always_comb begin
        state_s     = state_r;
        run_sym_s   = run_sym_r;
        run_rem_s   = run_rem_r;
        pos_s       = pos_r;
        buf_s       = buf_r;
        out_valid_s = stall_s;
        out_data_s  = out_data_r;
`ifdef RLE_FLUSH_EN
        last_s      = stall_s ? last_r : 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (flush_req_s) begin
                    if (!stall_s && (pos_r != '0)) begin
                        out_data_s  = buf_r;
                        out_valid_s = 1'b1;
                        pos_s       = '0;
                        buf_s       = '0;
`ifdef RLE_FLUSH_EN
                        last_s      = 1'b1;
`endif
                    end else begin
                        state_s = IDLE;
                    end
                end else if (in_valid) begin
                    run_sym_s = in_sym;
                    run_rem_s = in_len;
                    state_s   = (in_len != '0) ? EXPAND : IDLE;
                end else begin
                    state_s = IDLE;
                end
            end
            EXPAND: begin
                if (!stall_s) begin
                    run_rem_s = run_rem_r - LEN_W'(k_s);
                    state_s   = (run_rem_r == LEN_W'(k_s)) ? IDLE : EXPAND;
                    if (word_done_s) begin
                        out_data_s  = fill_buf_s;
                        out_valid_s = 1'b1;
                        pos_s       = '0;
                        buf_s       = '0;
`ifdef RLE_FLUSH_EN
                        last_s      = 1'b0;
`endif
                    end else begin
                        pos_s = pos_r + k_s;
                        buf_s = fill_buf_s;
                    end
                end else begin
                    state_s = EXPAND;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            run_sym_r   <= '0;
            run_rem_r   <= '0;
            pos_r       <= '0;
            buf_r       <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
`ifdef RLE_FLUSH_EN
            last_r      <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            run_sym_r   <= run_sym_s;
            run_rem_r   <= run_rem_s;
            pos_r       <= pos_s;
            buf_r       <= buf_s;
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
`ifdef RLE_FLUSH_EN
            last_r      <= last_s;
`endif
        end
    end

endmodule

// File: tb/tb_rle_word_decompressor.sv
// Self-checking bench for rle_word_decompressor (SYM_W=1, WORD_W=8, LEN_W=5, plus a 4/16 instance).
module tb_rle_word_decompressor;

    localparam int SYM_W  = 1;
    localparam int WORD_W = 8;
    localparam int LEN_W  = 5;
    localparam int SLOTS  = WORD_W / SYM_W;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [SYM_W-1:0]  in_sym;
    logic [LEN_W-1:0]  in_len;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [WORD_W-1:0] out_data;
    logic              flush;
`ifdef RLE_FLUSH_EN
    logic              out_last;
    logic              b_out_last;
`endif

    logic        b_in_valid, b_in_ready, b_out_valid;
    logic [3:0]  b_in_sym;
    logic [4:0]  b_in_len;
    logic [15:0] b_out_data;

    int errors = 0;
    int checks = 0;

    logic [SYM_W-1:0]  pend[$];
    logic [WORD_W-1:0] exp_words[$];
    logic              exp_last[$];
    logic [WORD_W-1:0] got_words[$];
    logic              rand_ready = 1'b0;
    logic              ready_fix  = 1'b1;
    logic              held_valid = 1'b0;
    logic [WORD_W-1:0] held_data;

    always #5 clk = ~clk;

    rle_word_decompressor #(.SYM_W(SYM_W), .WORD_W(WORD_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sym(in_sym), .in_len(in_len), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data)
`ifdef RLE_FLUSH_EN
        , .flush(flush), .out_last(out_last)
`endif
    );

    rle_word_decompressor #(.SYM_W(4), .WORD_W(16), .LEN_W(5)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_sym(b_in_sym), .in_len(b_in_len), .out_valid(b_out_valid), .out_ready(1'b1),
        .out_data(b_out_data)
`ifdef RLE_FLUSH_EN
        , .flush(1'b0), .out_last(b_out_last)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: a flat stream of symbols, cut into words every SLOTS symbols.
    task automatic model_run(input logic [SYM_W-1:0] s, input int len);
        for (int i = 0; i < len; i++) begin
            pend.push_back(s);
            if (pend.size() == SLOTS) begin
                logic [WORD_W-1:0] w;
                w = '0;
                for (int j = 0; j < SLOTS; j++) w[j*SYM_W +: SYM_W] = pend[j];
                exp_words.push_back(w);
                exp_last.push_back(1'b0);
                pend.delete();
            end
        end
    endtask

    task automatic model_flush();
        if (pend.size() > 0) begin
            logic [WORD_W-1:0] w;
            w = '0;
            for (int j = 0; j < pend.size(); j++) w[j*SYM_W +: SYM_W] = pend[j];
            exp_words.push_back(w);
            exp_last.push_back(1'b1);
            pend.delete();
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_run(input logic [SYM_W-1:0] s, input int len);
        int guard = 0;
        in_sym   = s;
        in_len   = len[LEN_W-1:0];
        in_valid = 1'b1;
        while (!in_ready && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stuck at 0, required 1");
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            model_run(s, len);
        end
    endtask

    task automatic wait_idle(input string name);
        int g = 0;
        while ((exp_words.size() != 0 || !in_ready) && g < 500) begin
            @(posedge clk); #1;
            g++;
        end
        check(name, 32'(exp_words.size()), 32'd0);
    endtask

    function automatic logic [WORD_W-1:0] got_back(input int back);
        return got_words[got_words.size() - 1 - back];
    endfunction

    // Output ready: fixed level or random backpressure.
    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fix;
    end

    // Compare every transferred word against the reference and check stall stability.
    always @(negedge clk) begin
        if (reset_n) begin
            if (held_valid) check("stall_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, held_data});
            if (out_valid && out_ready) begin
                held_valid = 1'b0;
                checks++;
                if (exp_words.size() == 0) begin
                    errors++;
                    $display("FAIL extra_word: got %h expected no word", out_data);
                end else begin
                    check("word", 32'(out_data), 32'(exp_words.pop_front()));
`ifdef RLE_FLUSH_EN
                    check("last", 32'(out_last), 32'(exp_last.pop_front()));
`else
                    void'(exp_last.pop_front());
`endif
                    got_words.push_back(out_data);
                end
            end else if (out_valid) begin
                held_valid = 1'b1;
                held_data  = out_data;
            end else begin
                held_valid = 1'b0;
            end
        end else begin
            held_valid = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int g;
        reset_n = 1'b0; in_valid = 1'b0; in_sym = '0; in_len = '0; flush = 1'b0;
        b_in_valid = 1'b0; b_in_sym = 4'd0; b_in_len = 5'd0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        #20;
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // 4-bit symbols into 16-bit words: (A,3),(5,1) -> 5AAA
        check("b_ready0", 32'(b_in_ready), 32'd1);
        b_in_sym = 4'hA; b_in_len = 5'd3; b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_sym = 4'h5; b_in_len = 5'd1;
        check("b_busy", 32'(b_in_ready), 32'd0);
        @(posedge clk); #1;
        check("b_ready1", 32'(b_in_ready), 32'd1);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        check("b_early", 32'(b_out_valid), 32'd0);
        @(posedge clk); #1;
        check("b_valid", 32'(b_out_valid), 32'd1);
        check("b_data", 32'(b_out_data), 32'h5AAA);

        // One full word, one edge after accept
        send_run(1'b1, 8);
        check("t1_no_early", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_data", 32'(out_data), 32'hFF);
        check("t1_in_ready", 32'(in_ready), 32'd1);
        wait_idle("t1_drain");

        // Three short runs share a word
        n0 = got_words.size();
        send_run(1'b1, 3); send_run(1'b0, 2); send_run(1'b1, 3);
        wait_idle("t2_drain");
        check("t2_count", 32'(got_words.size()), 32'(n0 + 1));
        check("t2_word", 32'(got_back(0)), 32'hE7);

        // Run spanning words
        n0 = got_words.size();
        send_run(1'b1, 20); send_run(1'b0, 4);
        wait_idle("t3_drain");
        check("t3_count", 32'(got_words.size()), 32'(n0 + 3));
        check("t3_w0", 32'(got_back(2)), 32'hFF);
        check("t3_w1", 32'(got_back(1)), 32'hFF);
        check("t3_w2", 32'(got_back(0)), 32'h0F);

        // Backpressure
        n0 = got_words.size();
        ready_fix = 1'b0;
        @(posedge clk); #1;
        send_run(1'b1, 16);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_data", 32'(out_data), 32'hFF);
            check("t4_in_ready", 32'(in_ready), 32'd0);
        end
        check("t4_no_xfer", 32'(got_words.size()), 32'(n0));
        ready_fix = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t4_back2back", 32'(out_valid), 32'd1);
        check("t4_first", 32'(got_words.size()), 32'(n0 + 1));
        @(posedge clk); #1;
        check("t4_done", 32'(out_valid), 32'd0);
        check("t4_second", 32'(got_words.size()), 32'(n0 + 2));
        wait_idle("t4_drain");

        // Zero-length run has no effect
        n0 = got_words.size();
        send_run(1'b0, 0); send_run(1'b1, 8);
        wait_idle("t5_drain");
        repeat (3) @(posedge clk);
        #1;
        check("t5_count", 32'(got_words.size()), 32'(n0 + 1));
        check("t5_word", 32'(got_back(0)), 32'hFF);

        // Reset in the middle of a run
        n0 = got_words.size();
        send_run(1'b1, 20);
        g = 0;
        while (got_words.size() == n0 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        check("t6_first", 32'(got_words.size()), 32'(n0 + 1));
        reset_n = 1'b0;
        pend.delete(); exp_words.delete(); exp_last.delete();
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_data", 32'(out_data), 32'd0);
        check("t6_rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        check("t6_rel_ready", 32'(in_ready), 32'd1);
        n0 = got_words.size();
        send_run(1'b1, 8);
        wait_idle("t6_drain");
        check("t6_count", 32'(got_words.size()), 32'(n0 + 1));
        check("t6_word", 32'(got_back(0)), 32'hFF);

        // Random runs with random backpressure
        rand_ready = 1'b1;
        for (int r = 0; r < 150; r++) begin
            send_run(SYM_W'($urandom_range(0, 1)), int'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        wait_idle("rand_drain");
        rand_ready = 1'b0;
        ready_fix  = 1'b1;
        @(posedge clk); #1;

`ifdef RLE_FLUSH_EN
        // Drain leftover partial word, then flush tests
        flush = 1'b1;
        model_flush();
        g = 0;
        while ((exp_words.size() != 0 || out_valid) && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        flush = 1'b0;
        check("fl_drain", 32'(exp_words.size()), 32'd0);
        @(posedge clk); #1;
        send_run(1'b1, 3);
        flush = 1'b1;
        model_flush();
        @(posedge clk); #1;
        check("fl_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        check("fl_valid", 32'(out_valid), 32'd1);
        check("fl_data", 32'(out_data), 32'h07);
        check("fl_last", 32'(out_last), 32'd1);
        @(posedge clk); #1;
        check("fl_clear", 32'(out_last), 32'd0);
        n0 = got_words.size();
        flush = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        flush = 1'b0;
        check("fl_empty", 32'(got_words.size()), 32'(n0));
        check("fl_empty_valid", 32'(out_valid), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
